// File: rtl/mem_responder_if.sv
// Memory request/response bundle between the control FSM (master)
// and the memory-side responder (slave).
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: serves level-held read/write requests from an
// internal word array after a fixed per-operation latency and signals
// completion with a single-cycle mem_resp pulse. mem_err is sticky.
module mem_responder #(
  parameter int ADDR_WIDTH    = 10,
  parameter int READ_LATENCY  = 3,
  parameter int WRITE_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
  localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);
  localparam int         DEPTH  = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_is_write;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic [3:0]            r_cnt;
  logic                  r_err;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [0:DEPTH-1];

  logic                  w_req_one;
  logic                  w_req_both;
  logic                  w_active;
  logic [3:0]            w_lat_sel;
  logic [ADDR_WIDTH-1:0] w_in_idx;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic                  w_rd_is_write;
  logic                  w_load_rdata;
  logic                  w_unused_addr;

  assign w_req_one  = bus.mem_read ^ bus.mem_write;
  assign w_req_both = bus.mem_read & bus.mem_write;
  // The request line that belongs to the operation in flight.
  assign w_active   = r_is_write ? bus.mem_write : bus.mem_read;
  assign w_lat_sel  = bus.mem_write ? WR_LAT : RD_LAT;
  assign w_in_idx   = bus.mem_address[ADDR_WIDTH+1:2];

  // Byte offset and bits above the array size are ignored (aliasing).
  assign w_unused_addr = ^{bus.mem_address[31:ADDR_WIDTH+2], bus.mem_address[1:0]};

  // With a latency of one, RESP is entered straight from IDLE, before the
  // request fields are latched, so the read port uses the live inputs then.
  assign w_rd_idx      = (r_state == S_IDLE) ? w_in_idx : r_idx;
  assign w_rd_is_write = (r_state == S_IDLE) ? bus.mem_write : r_is_write;
  assign w_load_rdata  = (w_state_next == S_RESP) && !w_rd_is_write;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a dropped request line in BUSY aborts to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_one) begin
          w_state_next = (w_lat_sel == 4'd1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (!w_active) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state and the response registers.
  always_comb begin
    bus.mem_resp  = (r_state == S_RESP);
    bus.mem_rdata = r_rdata;
    bus.mem_err   = r_err;
  end

  // Request latching, latency counter, sticky error and read-data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_write <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_one) begin
            r_is_write <= bus.mem_write;
            r_idx      <= w_in_idx;
            r_wdata    <= bus.mem_wdata;
            r_be       <= bus.mem_byte_enable;
            r_cnt      <= w_lat_sel - 4'd1;
          end else if (w_req_both) begin
            r_err <= 1'b1;
          end
        end
        S_BUSY: begin
          if (!w_active) begin
            r_err <= 1'b1;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_cnt <= '0;
      endcase
      if (w_load_rdata) begin
        r_rdata <= r_mem[w_rd_idx];
      end
    end
  end

  // Write commit on the edge that leaves RESP, enabled lanes only.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_RESP && r_is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
